systolic_feeder: RTL and testbench
==================================

Name: systolic_feeder

Overview:
Tile sequencer that drives the dense systolic array's control and data inputs for one GEMM tile. It accepts weight rows and activation vectors over valid/ready streams and performs four phases in order: weight load, accumulator clear, activation streaming, and pipeline flush. It signals tile completion when the array outputs are final. It sits between the tile buffers and the array inside accel_top.

Parameters:
N_ROWS, 14, array rows; activation lanes.
N_COLS, 14, array columns; weight lanes.
PIPE, 1, PE pipeline depth; must match the array setting.
K_W, 16, width of the tile reduction length.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  one-cycle tile start pulse
k_len  in  K_W  activation beats in the tile; sampled on start
row_mask  in  N_ROWS  active rows; sampled on start
w_valid  in  1  weight row valid
w_ready  out  1  weight row ready
w_data  in  N_COLS*8  one weight row, INT8 per column
a_valid  in  1  activation vector valid
a_ready  out  1  activation vector ready
a_data  in  N_ROWS*8  INT8 activation per row
sa_en  out  1  array compute enable
sa_clr  out  1  array accumulator clear
sa_load_weight  out  1  array weight load
sa_row_en  out  N_ROWS  array row enables
sa_a_in_flat  out  N_ROWS*8  activations to the array
sa_b_in_flat  out  N_COLS*8  weights to the array
busy  out  1  high from the cycle after an accepted start until tile_done
tile_done  out  1  one-cycle pulse; c_out_flat is valid in this cycle

Behaviour:
- Interface decision: single clock clk; reset rst is synchronous and active-high.
- All sa_* outputs, busy and tile_done are registered.
- Reset values: all outputs 0; FSM in IDLE. Reset asserted mid-tile returns to IDLE within one cycle, outputs drop to 0, and partial work is discarded.
- FSM states: IDLE -> LOAD_W -> CLEAR -> STREAM -> FLUSH -> DONE -> IDLE.
- IDLE: start=1 latches k_len and row_mask, sets row index r=0 and goes to LOAD_W. start is ignored in any other state.
- LOAD_W WAIT substate: w_ready=1.
  - On a w_valid&w_ready handshake, w_data is registered to sa_b_in_flat.
  - If row_mask[r]=1: enter HOLD for exactly N_COLS cycles, with sa_load_weight=1 and sa_row_en=(1<<r) in each cycle.
  - If row_mask[r]=0: the beat is consumed with no HOLD.
  - After row N_ROWS-1 completes, go to CLEAR.
  - Exactly N_ROWS beats are consumed per tile.
- CLEAR: one cycle with sa_clr=1, sa_row_en=row_mask, sa_en=0, sa_load_weight=0.
- STREAM:
  - a_ready=1 while the accepted-beat count is below k_len.
  - Each handshake registers a_data to sa_a_in_flat, with sa_en=1 and sa_row_en=row_mask in the following cycle.
  - Cycles without a handshake drive sa_en=0 (array frozen, skew registers held) and sa_a_in_flat=0.
  - After k_len accepted beats, go to FLUSH. If k_len=0, STREAM is skipped.
- FLUSH: exactly N_ROWS+N_COLS-2+PIPE cycles (27 at defaults) with sa_en=1 and sa_a_in_flat=0, draining the skew and the PE pipeline.
- DONE: tile_done=1 for one cycle; all sa_* outputs are 0; busy falls in the same cycle; next state IDLE.
- sa_en and sa_load_weight are never both 1.
- w_ready is low outside LOAD_W WAIT; a_ready is low outside STREAM.
- Counters:
  - Row counter: $clog2(N_ROWS) bits.
  - Hold/flush counter: wide enough for max(N_COLS, N_ROWS+N_COLS-2+PIPE).
  - Beat counter: K_W bits, compared against the latched k_len. k_len=2^K_W-1 must not wrap.
- Latency, start to tile_done with full mask and no stalls: 1 + N_ROWS*(1+N_COLS) + 1 + k_len + flush + 1.

Decomposition:
- Package systolic_pkg holds:
  - fsm_state_e (IDLE, LOAD_W, CLEAR, STREAM, FLUSH, DONE)
  - function flush_cycles(N_ROWS, N_COLS, PIPE)
  - the INT8 lane width constant (8)
- One sub-module, feeder_phase_counter: a loadable down-counter with a zero flag, reused for HOLD and FLUSH.

Test Plan:
- Full tile, defaults, k_len=4, row_mask all ones, valid always 1:
  - 14 w handshakes, each followed by 14 cycles of sa_load_weight with one-hot sa_row_en.
  - Then one sa_clr cycle, 4 sa_en data cycles, and 27 flush cycles.
  - tile_done 1+14*15+1+4+27+1=244 cycles after start; no sa_en/sa_load_weight overlap.
- row_mask=14'h0005: 14 weight beats consumed; HOLD occurs only for rows 0 and 2; sa_row_en during STREAM is 0x0005.
- a_valid toggling 1,0,1,0 with k_len=3: sa_en=0 on the idle cycles, sa_a_in_flat=0 on those cycles, and exactly 3 sa_en data cycles before FLUSH.
- k_len=0: LOAD_W, then CLEAR, then FLUSH of 27 cycles, then tile_done; a_ready never asserts.
- rst=1 during STREAM beat 2: next cycle all outputs are 0 and the FSM is in IDLE; a new start runs a full tile correctly.
- start pulsed while busy: ignored; k_len and row_mask are unchanged and tile_done fires only once.

Source files
------------

// File: rtl/systolic_pkg.sv
// Shared types and constants for the systolic array tile feeder.
package systolic_pkg;

    localparam int LANE_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_W,
        CLEAR,
        STREAM,
        FLUSH,
        DONE
    } fsm_state_e;

    // Cycles needed to drain the row/column skew plus the PE pipeline.
    function automatic int flush_cycles(input int n_rows, input int n_cols, input int pipe);
        return n_rows + n_cols - 2 + pipe;
    endfunction

endpackage

// File: rtl/feeder_phase_counter.sv
// Loadable down-counter with a zero flag; times weight HOLD runs and the FLUSH drain.
module feeder_phase_counter #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && count != '0) begin
            count <= count - W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/systolic_feeder.sv
// Tile sequencer for the dense systolic array: weight load, accumulator clear,
// activation streaming and pipeline flush, then a one-cycle tile_done.
module systolic_feeder
    import systolic_pkg::*;
#(
    parameter int N_ROWS = 14,
    parameter int N_COLS = 14,
    parameter int PIPE   = 1,
    parameter int K_W    = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [K_W-1:0]             k_len,
    input  logic [N_ROWS-1:0]          row_mask,
    input  logic                       w_valid,
    output logic                       w_ready,
    input  logic [N_COLS*LANE_W-1:0]   w_data,
    input  logic                       a_valid,
    output logic                       a_ready,
    input  logic [N_ROWS*LANE_W-1:0]   a_data,
    output logic                       sa_en,
    output logic                       sa_clr,
    output logic                       sa_load_weight,
    output logic [N_ROWS-1:0]          sa_row_en,
    output logic [N_ROWS*LANE_W-1:0]   sa_a_in_flat,
    output logic [N_COLS*LANE_W-1:0]   sa_b_in_flat,
    output logic                       busy,
    output logic                       tile_done
);

    localparam int FLUSH_N = flush_cycles(N_ROWS, N_COLS, PIPE);
    localparam int PH_MAX  = (FLUSH_N > N_COLS) ? FLUSH_N : N_COLS;
    localparam int PH_W    = $clog2(PH_MAX + 1);
    localparam int ROW_W   = (N_ROWS > 1) ? $clog2(N_ROWS) : 1;

    localparam logic [ROW_W-1:0] LAST_ROW   = ROW_W'(N_ROWS - 1);
    localparam logic [PH_W-1:0]  HOLD_LOAD  = PH_W'(N_COLS - 1);
    localparam logic [PH_W-1:0]  FLUSH_LOAD = PH_W'(FLUSH_N - 1);

    fsm_state_e          state_q, state_d;
    logic                holding_q, holding_d;
    logic [ROW_W-1:0]    row_q, row_d;
    logic [K_W-1:0]      beat_q, beat_d;
    logic [K_W-1:0]      k_len_q, k_len_d;
    logic [N_ROWS-1:0]   mask_q, mask_d;

    logic                ph_load, ph_dec, ph_zero, row_done;
    logic [PH_W-1:0]     ph_load_val;

    logic                en_d, clr_d, lw_d, busy_d, done_d;
    logic [N_ROWS-1:0]   row_en_d;
    logic [N_ROWS*LANE_W-1:0] a_d;
    logic [N_COLS*LANE_W-1:0] b_d;

    logic w_hs, a_hs;

    // valid/ready: a beat transfers at a rising edge where both are high;
    // ready is decoded from state only and never looks at valid.
    assign w_ready = (state_q == LOAD_W) && !holding_q;
    assign a_ready = (state_q == STREAM) && (beat_q < k_len_q);
    assign w_hs    = w_valid && w_ready;
    assign a_hs    = a_valid && a_ready;

    feeder_phase_counter #(.W(PH_W)) u_phase (
        .clk      (clk),
        .rst      (rst),
        .load     (ph_load),
        .load_val (ph_load_val),
        .dec      (ph_dec),
        .zero     (ph_zero)
    );

    always_comb begin
        state_d     = state_q;
        holding_d   = holding_q;
        row_d       = row_q;
        beat_d      = beat_q;
        k_len_d     = k_len_q;
        mask_d      = mask_q;
        ph_load     = 1'b0;
        ph_load_val = HOLD_LOAD;
        ph_dec      = 1'b0;
        row_done    = 1'b0;
        en_d        = 1'b0;
        clr_d       = 1'b0;
        lw_d        = 1'b0;
        row_en_d    = '0;
        a_d         = '0;
        b_d         = sa_b_in_flat;
        busy_d      = 1'b0;
        done_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    k_len_d   = k_len;
                    mask_d    = row_mask;
                    row_d     = '0;
                    beat_d    = '0;
                    holding_d = 1'b0;
                    state_d   = LOAD_W;
                end
            end
            LOAD_W: begin
                if (!holding_q) begin
                    if (w_hs) begin
                        b_d = w_data;
                        if (mask_q[row_q]) begin
                            holding_d = 1'b1;
                            ph_load   = 1'b1;
                        end else begin
                            row_done = 1'b1;
                        end
                    end
                end else if (ph_zero) begin
                    holding_d = 1'b0;
                    row_done  = 1'b1;
                end else begin
                    ph_dec = 1'b1;
                end
                if (row_done) begin
                    if (row_q == LAST_ROW) state_d = CLEAR;
                    else                   row_d   = row_q + ROW_W'(1);
                end
            end
            CLEAR: begin
                if (k_len_q == '0) begin
                    state_d     = FLUSH;
                    ph_load     = 1'b1;
                    ph_load_val = FLUSH_LOAD;
                end else begin
                    state_d = STREAM;
                end
            end
            STREAM: begin
                if (a_hs) begin
                    beat_d   = beat_q + K_W'(1);
                    en_d     = 1'b1;
                    row_en_d = mask_q;
                    a_d      = a_data;
                end else if (beat_q == k_len_q) begin
                    // The last beat is already on the array this cycle.
                    state_d     = FLUSH;
                    ph_load     = 1'b1;
                    ph_load_val = FLUSH_LOAD;
                end
            end
            FLUSH: begin
                if (ph_zero) state_d = DONE;
                else         ph_dec  = 1'b1;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Outputs are decoded from the next state so they line up with it once registered.
        if (state_d == LOAD_W && holding_d) begin
            lw_d     = 1'b1;
            row_en_d = N_ROWS'(1) << row_d;
        end
        if (state_d == CLEAR) begin
            clr_d    = 1'b1;
            row_en_d = mask_d;
        end
        if (state_d == FLUSH) begin
            en_d     = 1'b1;
            row_en_d = mask_d;
        end
        if (state_d == DONE) begin
            done_d = 1'b1;
            b_d    = '0;
        end
        busy_d = (state_d != IDLE) && (state_d != DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            holding_q      <= 1'b0;
            row_q          <= '0;
            beat_q         <= '0;
            k_len_q        <= '0;
            mask_q         <= '0;
            sa_en          <= 1'b0;
            sa_clr         <= 1'b0;
            sa_load_weight <= 1'b0;
            sa_row_en      <= '0;
            sa_a_in_flat   <= '0;
            sa_b_in_flat   <= '0;
            busy           <= 1'b0;
            tile_done      <= 1'b0;
        end else begin
            state_q        <= state_d;
            holding_q      <= holding_d;
            row_q          <= row_d;
            beat_q         <= beat_d;
            k_len_q        <= k_len_d;
            mask_q         <= mask_d;
            sa_en          <= en_d;
            sa_clr         <= clr_d;
            sa_load_weight <= lw_d;
            sa_row_en      <= row_en_d;
            sa_a_in_flat   <= a_d;
            sa_b_in_flat   <= b_d;
            busy           <= busy_d;
            tile_done      <= done_d;
        end
    end

endmodule

// File: tb/tb_systolic_feeder.sv
// Self-checking bench for systolic_feeder: table of tiles plus reset and spurious-start sequences.
module tb_systolic_feeder;

    localparam int N_ROWS  = 14;
    localparam int N_COLS  = 14;
    localparam int PIPE    = 1;
    localparam int K_W     = 16;
    localparam int FLUSH_N = N_ROWS + N_COLS - 2 + PIPE;
    localparam int AW      = N_ROWS * 8;
    localparam int BW      = N_COLS * 8;
    localparam int TIMEOUT = 3000;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [K_W-1:0]    k_len;
    logic [N_ROWS-1:0] row_mask;
    logic              w_valid, w_ready;
    logic [BW-1:0]     w_data;
    logic              a_valid, a_ready;
    logic [AW-1:0]     a_data;
    logic              sa_en, sa_clr, sa_load_weight;
    logic [N_ROWS-1:0] sa_row_en;
    logic [AW-1:0]     sa_a_in_flat;
    logic [BW-1:0]     sa_b_in_flat;
    logic              busy, tile_done;

    always #5 clk = ~clk;

    systolic_feeder #(.N_ROWS(N_ROWS), .N_COLS(N_COLS), .PIPE(PIPE), .K_W(K_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .k_len          (k_len),
        .row_mask       (row_mask),
        .w_valid        (w_valid),
        .w_ready        (w_ready),
        .w_data         (w_data),
        .a_valid        (a_valid),
        .a_ready        (a_ready),
        .a_data         (a_data),
        .sa_en          (sa_en),
        .sa_clr         (sa_clr),
        .sa_load_weight (sa_load_weight),
        .sa_row_en      (sa_row_en),
        .sa_a_in_flat   (sa_a_in_flat),
        .sa_b_in_flat   (sa_b_in_flat),
        .busy           (busy),
        .tile_done      (tile_done)
    );

    typedef struct {
        logic [K_W-1:0]    k;
        logic [N_ROWS-1:0] mask;
        int                stall;
        int                abort_beat;
        int                spur_at;
    } tile_t;

    logic [BW-1:0]     exp_w_q[$];
    logic [N_ROWS-1:0] exp_row_q[$];
    logic [AW-1:0]     exp_a_q[$];

    int checks   = 0;
    int failures = 0;

    task automatic check_int(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic check_vec(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic logic [AW-1:0] rand_vec();
        logic [127:0] t;
        for (int i = 0; i < 4; i++) t[i*32 +: 32] = $urandom;
        if (t[AW-1:0] == '0) t[0] = 1'b1;
        return t[AW-1:0];
    endfunction

    function automatic tile_t mk(input int k, input int mask, input int stall, input int abort_beat,
                                 input int spur_at);
        tile_t t;
        t.k          = K_W'(k);
        t.mask       = N_ROWS'(mask);
        t.stall      = stall;
        t.abort_beat = abort_beat;
        t.spur_at    = spur_at;
        return t;
    endfunction

    task automatic run_tile(input int id, input tile_t t);
        int cyc, j, w_idx, a_hs_cnt, hold_runs, run_len, clr_cnt, clr_bad, data_cnt, flush_cnt;
        int overlap, a_bad, row_bad, w_rdy_cnt, a_rdy_cnt, busy_cnt, extra_done, idle_bad;
        int exp_a_rdy, exp_lat, tail_n;
        bit done, aborted, prev_lw;
        logic [BW-1:0] eb;
        logic [N_ROWS-1:0] er;
        logic [AW-1:0] ea;
        string p;
        p = $sformatf("t%0d", id);
        {cyc, j, w_idx, a_hs_cnt, hold_runs, run_len, clr_cnt, clr_bad, data_cnt, flush_cnt} = '0;
        {overlap, a_bad, row_bad, w_rdy_cnt, a_rdy_cnt, busy_cnt, extra_done, idle_bad} = '0;
        done = 0; aborted = 0; prev_lw = 0;
        exp_w_q.delete(); exp_row_q.delete(); exp_a_q.delete();

        @(negedge clk);
        start    = 1'b1;
        k_len    = t.k;
        row_mask = t.mask;
        w_valid  = 1'b1;
        w_data   = rand_vec();
        a_valid  = 1'b1;
        a_data   = rand_vec();

        while (!done && cyc < TIMEOUT) begin
            @(negedge clk);
            cyc++;
            if (aborted) begin
                check_int({p, "_rst_ctrl"}, int'({sa_en, sa_clr, sa_load_weight, busy, tile_done,
                                                  w_ready, a_ready}), 0);
                check_vec({p, "_rst_row_en"}, 128'(sa_row_en), '0);
                check_vec({p, "_rst_a"}, 128'(sa_a_in_flat), '0);
                check_vec({p, "_rst_b"}, 128'(sa_b_in_flat), '0);
                rst = 1'b0;
                break;
            end
            // Monitor the cycle that the last rising edge produced.
            if (sa_load_weight) begin
                if (!prev_lw) begin
                    hold_runs++;
                    check_int({p, "_w_exp_avail"}, int'(exp_w_q.size() > 0), 1);
                    if (exp_w_q.size() > 0) begin
                        eb = exp_w_q.pop_front();
                        er = exp_row_q.pop_front();
                        check_vec({p, "_hold_b"}, 128'(sa_b_in_flat), 128'(eb));
                        check_vec({p, "_hold_row_en"}, 128'(sa_row_en), 128'(er));
                    end
                end
                run_len++;
            end else if (prev_lw) begin
                check_int({p, "_hold_len"}, run_len, N_COLS);
                run_len = 0;
            end
            prev_lw = sa_load_weight;
            if (sa_en && sa_load_weight) overlap++;
            if (sa_clr) begin
                clr_cnt++;
                if (sa_row_en != t.mask || sa_en || sa_load_weight) clr_bad++;
            end
            if (sa_en) begin
                if (sa_a_in_flat != '0) begin
                    data_cnt++;
                    if (sa_row_en != t.mask) row_bad++;
                    check_int({p, "_a_exp_avail"}, int'(exp_a_q.size() > 0), 1);
                    if (exp_a_q.size() > 0) begin
                        ea = exp_a_q.pop_front();
                        check_vec({p, "_stream_a"}, 128'(sa_a_in_flat), 128'(ea));
                    end
                end else begin
                    flush_cnt++;
                end
            end else if (sa_a_in_flat != '0) begin
                a_bad++;
            end
            if (w_ready) w_rdy_cnt++;
            if (a_ready) a_rdy_cnt++;
            if (busy) busy_cnt++;
            if (tile_done) begin
                done = 1;
                check_int({p, "_done_busy"}, int'(busy), 0);
                check_int({p, "_done_sa_zero"}, int'(sa_en | sa_clr | sa_load_weight | (|sa_row_en) |
                                                     (|sa_a_in_flat) | (|sa_b_in_flat)), 0);
            end
            // Drive the next cycle; k_len/row_mask are garbage after the start cycle.
            start    = (cyc == t.spur_at);
            k_len    = K_W'($urandom);
            row_mask = N_ROWS'($urandom);
            w_valid  = 1'b1;
            w_data   = rand_vec();
            if (w_ready) begin
                if (w_idx < N_ROWS && t.mask[w_idx]) begin
                    exp_w_q.push_back(w_data);
                    exp_row_q.push_back(N_ROWS'(1) << w_idx);
                end
                w_idx++;
            end
            a_data  = rand_vec();
            a_valid = (t.stall == 0) ? 1'b1 : ((j % 2) == 0);
            if (a_ready) begin
                if (a_valid) begin
                    a_hs_cnt++;
                    if (t.abort_beat != 0 && a_hs_cnt == t.abort_beat) begin
                        rst     = 1'b1;
                        aborted = 1;
                    end else begin
                        exp_a_q.push_back(a_data);
                    end
                end
                j++;
            end
        end
        start = 1'b0;

        if (!aborted) begin
            exp_a_rdy = (t.k == 0) ? 0 : ((t.stall != 0) ? 2 * int'(t.k) - 1 : int'(t.k));
            exp_lat   = 1 + N_ROWS + N_COLS * $countones(t.mask) + 1 + exp_a_rdy + 1 + FLUSH_N;
            check_int({p, "_done_seen"}, int'(done), 1);
            if (t.k != 0) check_int({p, "_latency"}, cyc, exp_lat);
            check_int({p, "_hold_runs"}, hold_runs, $countones(t.mask));
            check_int({p, "_w_beats"}, w_rdy_cnt, N_ROWS);
            check_int({p, "_a_ready_cycles"}, a_rdy_cnt, exp_a_rdy);
            check_int({p, "_clr_cycles"}, clr_cnt, 1);
            check_int({p, "_clr_bad"}, clr_bad, 0);
            check_int({p, "_data_cycles"}, data_cnt, int'(t.k));
            check_int({p, "_flush_cycles"}, flush_cnt, FLUSH_N);
            check_int({p, "_en_lw_overlap"}, overlap, 0);
            check_int({p, "_idle_a_nonzero"}, a_bad, 0);
            check_int({p, "_stream_row_en_bad"}, row_bad, 0);
            check_int({p, "_busy_cycles"}, busy_cnt, cyc - 1);
            check_int({p, "_leftover_exp"}, exp_w_q.size() + exp_a_q.size(), 0);
            tail_n = (t.spur_at != 0) ? 40 : 2;
            for (int i = 0; i < tail_n; i++) begin
                @(negedge clk);
                if (tile_done) extra_done++;
                if (busy || sa_en || sa_clr || sa_load_weight || sa_row_en != '0 ||
                    sa_a_in_flat != '0 || sa_b_in_flat != '0) idle_bad++;
            end
            check_int({p, "_extra_done"}, extra_done, 0);
            check_int({p, "_idle_outputs"}, idle_bad, 0);
        end
        exp_w_q.delete(); exp_row_q.delete(); exp_a_q.delete();
    endtask

    tile_t tbl[6];

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        k_len    = '0;
        row_mask = '0;
        w_valid  = 1'b0;
        w_data   = '0;
        a_valid  = 1'b0;
        a_data   = '0;

        tbl[0] = mk(4, 'h3FFF, 0, 0, 0);
        tbl[1] = mk(4, 'h0005, 0, 0, 0);
        tbl[2] = mk(3, 'h3FFF, 1, 0, 0);
        tbl[3] = mk(0, 'h3FFF, 0, 0, 0);
        tbl[4] = mk(6, 'h2A51, 1, 0, 0);
        tbl[5] = mk(1, 'h2000, 0, 0, 0);

        repeat (3) @(negedge clk);
        check_int("reset_ctrl", int'({sa_en, sa_clr, sa_load_weight, busy, tile_done}), 0);
        check_int("reset_ready", int'({w_ready, a_ready}), 0);
        check_vec("reset_row_en", 128'(sa_row_en), '0);
        check_vec("reset_a", 128'(sa_a_in_flat), '0);
        check_vec("reset_b", 128'(sa_b_in_flat), '0);
        rst = 1'b0;

        for (int i = 0; i < 6; i++) run_tile(i, tbl[i]);

        // Reset during STREAM beat 2, then a clean full tile.
        run_tile(10, mk(4, 'h3FFF, 0, 2, 0));
        run_tile(11, mk(4, 'h3FFF, 0, 0, 0));

        // start pulsed mid-tile with different k_len/row_mask must be ignored.
        run_tile(12, mk(5, 'h0F0F, 0, 0, 50));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
